// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction-fetch front end. Owns the fetch PC, issues word
//            requests over a valid/ready channel (in-order responses), and
//            buffers returned instructions tagged with their PCs for decode.
//            A taken branch redirects the PC, flushes the queue and discards
//            every response still in flight.
// Ports    : clk, rst_n (async, active-low)
//            imem_req_valid/ready/addr  - fetch request channel
//            imem_rsp_valid/data        - in-order response, no backpressure
//            branch_taken/target_pc     - redirect from execute
//            stall                      - decode cannot accept
//            instr_valid/instr/instr_pc - queue head to decode
//            misalign_trap              - only with FETCH_MISALIGN_TRAP_EN
// Options  : `define FETCH_MISALIGN_TRAP_EN to trap (and halt fetch) on a
//            redirect to a non-word-aligned target instead of clearing the
//            two low target bits.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        branch_taken,
  input  logic [31:0] target_pc,
  input  logic        stall,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misalign_trap,
`endif
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] c_depth = FIFO_DEPTH[CW:0];

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] iq_cnt_q, iq_cnt_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0] iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;

  logic [31:0]   tag_mem_q [FIFO_DEPTH];
  logic [31:0]   iq_data_q [FIFO_DEPTH];
  logic [31:0]   iq_pc_q   [FIFO_DEPTH];

  logic [CW:0]   w_cap_sum;
  logic          w_halt;
  logic          w_req_fire;
  logic          w_rsp_ok;
  logic          w_rsp_keep;
  logic          w_rsp_drop;
  logic          w_iq_empty;
  logic          w_pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic          trap_q, trap_d;
  assign w_halt        = trap_q;
  assign misalign_trap = trap_q;
`else
  logic          w_unused_lsb;
  assign w_halt       = 1'b0;
  assign w_unused_lsb = ^target_pc[1:0];
`endif

  // Capacity counts both in-flight requests (including ones that will be
  // dropped) and queued instructions, so a response can never overflow.
  assign w_cap_sum      = {1'b0, out_cnt_q} + {1'b0, iq_cnt_q};
  assign imem_req_valid = rst_n & (w_cap_sum < c_depth) & ~branch_taken & ~w_halt;
  assign imem_req_addr  = pc_q;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_ok   = imem_rsp_valid & (out_cnt_q != '0);
  assign w_rsp_drop = w_rsp_ok & (drop_cnt_q != '0);
  assign w_rsp_keep = w_rsp_ok & (drop_cnt_q == '0);

  assign w_iq_empty  = (iq_cnt_q == '0);
  assign instr_valid = ~w_iq_empty & ~branch_taken;
  assign w_pop       = instr_valid & ~stall;
  assign instr       = w_iq_empty ? 32'h0 : iq_data_q[iq_rd_q];
  assign instr_pc    = w_iq_empty ? 32'h0 : iq_pc_q[iq_rd_q];

  always_comb begin
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q + CW'(w_req_fire) - CW'(w_rsp_ok);
    drop_cnt_d = drop_cnt_q;
    iq_cnt_d   = iq_cnt_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    iq_wr_d    = iq_wr_q;
    iq_rd_d    = iq_rd_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d     = trap_q;
`endif
    if (branch_taken) begin
      // No request fires in a redirect cycle, so everything still
      // outstanding after this edge belongs to the old path.
      drop_cnt_d = out_cnt_d;
      iq_cnt_d   = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      iq_wr_d    = '0;
      iq_rd_d    = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_d       = target_pc;
      trap_d     = (target_pc[1:0] != 2'b00);
`else
      pc_d       = {target_pc[31:2], 2'b00};
`endif
    end else begin
      if (w_req_fire) begin
        pc_d     = pc_q + 32'd4;
        tag_wr_d = tag_wr_q + AW'(1);
      end
      if (w_rsp_keep) begin
        tag_rd_d = tag_rd_q + AW'(1);
        iq_wr_d  = iq_wr_q + AW'(1);
      end
      if (w_rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (w_pop) begin
        iq_rd_d = iq_rd_q + AW'(1);
      end
      iq_cnt_d = iq_cnt_q + CW'(w_rsp_keep) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      iq_cnt_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      iq_wr_q    <= '0;
      iq_rd_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      iq_cnt_q   <= iq_cnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      iq_wr_q    <= iq_wr_d;
      iq_rd_q    <= iq_rd_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= trap_d;
`endif
    end
  end

  // Storage needs no reset: tags are written before being read and the
  // queue outputs are forced to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      tag_mem_q[tag_wr_q] <= pc_q;
    end
    if (w_rsp_keep) begin
      iq_data_q[iq_wr_q] <= imem_rsp_data;
      iq_pc_q[iq_wr_q]   <= tag_mem_q[tag_rd_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Self-checking bench for if_fetch_unit: directed vector table,
//            hand-written corner sequences and randomized traffic compared
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] target_pc = 32'h0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .branch_taken   (branch_taken),
    .target_pc      (target_pc),
    .stall          (stall),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_trap  (misalign_trap),
`endif
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  typedef struct packed {logic [31:0] pc; logic drop;} req_t;
  typedef struct packed {logic [31:0] data; logic [31:0] pc;} ins_t;
  typedef struct packed {logic [31:0] addr; int due;} mem_t;
  typedef struct packed {
    logic rdy; logic br; logic [31:0] tgt;
    logic rv; logic [31:0] addr; logic iv; logic [31:0] ipc;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = 0;

  // Reference model: outstanding requests (with a dropped flag), decode
  // queue contents, fetch PC and trap flag.
  logic [31:0] m_pc = RST_PC;
  logic        m_trap = 1'b0;
  req_t        m_outq[$];
  ins_t        m_iq[$];
  mem_t        mq[$];

  vec_t vec[13];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  function automatic logic exp_rv();
    return ((m_outq.size() + m_iq.size()) < DEPTH) && !branch_taken && !m_trap;
  endfunction

  function automatic logic exp_iv();
    return (m_iq.size() > 0) && !branch_taken;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
  endtask

  task automatic chk_model();
    chk1("model_req_valid", imem_req_valid, exp_rv());
    chk("model_req_addr", imem_req_addr, m_pc);
    chk1("model_instr_valid", instr_valid, exp_iv());
    if (exp_iv()) begin
      chk("model_instr", instr, m_iq[0].data);
      chk("model_instr_pc", instr_pc, m_iq[0].pc);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("model_trap", misalign_trap, m_trap);
`endif
  endtask

  task automatic drive(input logic rdy, input logic br, input logic [31:0] tgt, input logic stl);
    imem_req_ready = rdy;
    branch_taken   = br;
    target_pc      = tgt;
    stall          = stl;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #2;
    chk_model();
  endtask

  task automatic advance();
    logic hs;
    req_t r;
    int   due;
    hs = exp_rv() && imem_req_ready;
    if (imem_rsp_valid) mq.delete(0);
    if (exp_iv() && !stall) m_iq.delete(0);
    if (imem_rsp_valid && m_outq.size() > 0) begin
      r = m_outq[0];
      m_outq.delete(0);
      if (!r.drop) m_iq.push_back('{data: imem_rsp_data, pc: r.pc});
    end
    if (branch_taken) begin
      m_iq.delete();
      foreach (m_outq[i]) m_outq[i].drop = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc   = target_pc;
      m_trap = (target_pc[1:0] != 2'b00);
`else
      m_pc   = target_pc & ~32'h3;
`endif
    end else if (hs) begin
      m_outq.push_back('{pc: m_pc, drop: 1'b0});
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: m_pc, due: due});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset(input int n);
    rst_n          = 1'b0;
    branch_taken   = 1'b0;
    imem_req_ready = 1'b1;
    stall          = 1'b0;
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("rst_trap", misalign_trap, 1'b0);
`endif
    // A stale response during reset must be ignored.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    imem_rsp_valid = 1'b0;
    rst_n  = 1'b1;
    m_pc   = RST_PC;
    m_trap = 1'b0;
    m_outq.delete();
    m_iq.delete();
    mq.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (m_outq.size() + m_iq.size() + mq.size()) > 0; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      advance();
    end
  endtask

  task automatic wait_iv(input string nm, input logic [31:0] exp_pc);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      if (instr_valid) begin
        seen = 1'b1;
        chk(nm, instr_pc, exp_pc);
        chk({nm, "_data"}, instr, mem_data(exp_pc));
      end
      advance();
    end
    chk1({nm, "_seen"}, seen, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    logic        rdy, stl, br;
    logic [31:0] tgt;

    // Zero-wait memory (1-cycle response) straight out of reset, then a
    // redirect to 0x100 with one request in flight.
    //            rdy   br    tgt           rv    addr          iv    ipc
    vec[0]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vec[1]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0004, 1'b0, 32'h0};
    vec[2]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
    vec[3]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    vec[4]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_000C, 1'b0, 32'h0};
    vec[5]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
    vec[6]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
    vec[7]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0014, 1'b0, 32'h0};
    vec[8]  = '{1'b1, 1'b1, 32'h100,     1'b0, 32'h0000_0018, 1'b0, 32'h0};
    vec[9]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0100, 1'b0, 32'h0};
    vec[10] = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0104, 1'b0, 32'h0};
    vec[11] = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100};
    vec[12] = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104};

    #1;
    apply_reset(3);

    lat = 1;
    for (int i = 0; i < 13; i++) begin
      drive(vec[i].rdy, vec[i].br, vec[i].tgt, 1'b0);
      chk1($sformatf("vec%0d_req_valid", i), imem_req_valid, vec[i].rv);
      chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vec[i].addr);
      chk1($sformatf("vec%0d_instr_valid", i), instr_valid, vec[i].iv);
      if (vec[i].iv) begin
        chk($sformatf("vec%0d_instr_pc", i), instr_pc, vec[i].ipc);
        chk($sformatf("vec%0d_instr", i), instr, mem_data(vec[i].ipc));
      end
      advance();
    end

    // Stall with a full queue: issue must stop, nothing lost afterwards.
    drain();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      if (k == 5) begin
        chk1("stall_full_req_valid", imem_req_valid, 1'b0);
        chk1("stall_full_instr_valid", instr_valid, 1'b1);
      end
      advance();
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      advance();
    end

    // Redirect with two requests outstanding (3-cycle memory).
    lat = 3;
    drain();
    drive(1'b1, 1'b0, 32'h0, 1'b0); advance();
    drive(1'b1, 1'b0, 32'h0, 1'b0); advance();
    drive(1'b1, 1'b1, 32'h100, 1'b0);
    chk1("br2_req_valid", imem_req_valid, 1'b0);
    advance();
    wait_iv("br2_first_pc", 32'h100);
    wait_iv("br2_second_pc", 32'h104);

    // Redirect coinciding with a response and an unaccepted request.
    lat = 1;
    drain();
    drive(1'b1, 1'b0, 32'h0, 1'b0); advance();
    drive(1'b0, 1'b1, 32'h100, 1'b0);
    chk1("redir_retract", imem_req_valid, 1'b0);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("redir_next_valid", imem_req_valid, 1'b1);
    chk("redir_next_addr", imem_req_addr, 32'h100);
    advance();
    wait_iv("redir_first_pc", 32'h100);

    // Reset mid-stream with one request outstanding.
    lat = 3;
    drain();
    drive(1'b1, 1'b0, 32'h0, 1'b0); advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0); advance();
    apply_reset(2);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk1("rst_restart_valid", imem_req_valid, 1'b1);
    chk("rst_restart_addr", imem_req_addr, RST_PC);
    advance();
    wait_iv("rst_first_pc", RST_PC);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect traps and halts fetch until the next redirect.
    lat = 1;
    drain();
    drive(1'b1, 1'b1, 32'h102, 1'b0); advance();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      chk1("trap_set", misalign_trap, 1'b1);
      chk1("trap_halt", imem_req_valid, 1'b0);
      chk("trap_pc", imem_req_addr, 32'h102);
      advance();
    end
    drive(1'b1, 1'b1, 32'h200, 1'b0); advance();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk1("trap_clear", misalign_trap, 1'b0);
    chk1("trap_resume_valid", imem_req_valid, 1'b1);
    chk("trap_resume_addr", imem_req_addr, 32'h200);
    advance();
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) lat = $urandom_range(1, 4);
      if (n == 2000) apply_reset(2);
      rdy = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 9) < 3);
      br  = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
`endif
      drive(rdy, br, tgt, stl);
      advance();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
